// File: rtl/shift_rows.sv
// Byte-serial AES ShiftRows with ping-pong 16-byte banks.
// Bytes enter and leave in column-major order.
module shift_rows (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] inbyte,
   output logic [7:0] outbyte,
   output logic       ready
);

   logic [7:0] mem [32];
   logic       wbank;
   logic       rbank;
   logic       streaming;
   logic [3:0] widx;
   logic [3:0] ridx;
   logic       done;

   // Output byte k at row r, col c reads input col (c+r) mod 4.
   function automatic logic [3:0] src_idx(input logic [3:0] k);
      logic [1:0] c;
      c = k[3:2] + k[1:0];
      return {c, k[1:0]};
   endfunction

   assign done = enable && (widx == 4'hf);

   always_ff @(posedge clock) begin
      if (enable)
         mem[{wbank, widx}] <= inbyte;
   end

   // Completion edge emits byte 0 itself, so streaming resumes at index 1.
   always_ff @(posedge clock) begin
      if (reset) begin
         wbank     <= 1'b0;
         widx      <= 4'h0;
         rbank     <= 1'b0;
         ridx      <= 4'h0;
         streaming <= 1'b0;
         outbyte   <= 8'h00;
         ready     <= 1'b0;
      end else begin
         if (enable) begin
            widx <= widx + 4'h1;
            if (widx == 4'hf)
               wbank <= ~wbank;
         end
         if (done) begin
            rbank     <= wbank;
            ridx      <= 4'h1;
            streaming <= 1'b1;
            outbyte   <= mem[{wbank, 4'h0}];
            ready     <= 1'b1;
         end else if (streaming) begin
            outbyte <= mem[{rbank, src_idx(ridx)}];
            ready   <= 1'b1;
            ridx    <= ridx + 4'h1;
            if (ridx == 4'hf)
               streaming <= 1'b0;
         end else begin
            outbyte <= 8'h00;
            ready   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_rows.sv
// Directed bench for shift_rows.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_shift_rows;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [7:0] inbyte;
   logic [7:0] outbyte;
   logic       ready;

   int passed;
   int total;

   logic [7:0] blk1 [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                             8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
   logic [7:0] exp1 [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                             8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
   logic [7:0] blk2 [16] = '{8'h49, 8'hde, 8'hd2, 8'h89, 8'h45, 8'hdb, 8'h96, 8'hf1,
                             8'h7f, 8'h39, 8'h87, 8'h1a, 8'h77, 8'h02, 8'h53, 8'h3b};
   logic [7:0] exp2 [16] = '{8'h49, 8'hdb, 8'h87, 8'h3b, 8'h45, 8'h39, 8'h53, 8'h89,
                             8'h7f, 8'h02, 8'hd2, 8'hf1, 8'h77, 8'hde, 8'h96, 8'h1a};
   logic [7:0] expid [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                              8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

   shift_rows dut (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable),
      .inbyte  (inbyte),
      .outbyte (outbyte),
      .ready   (ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic drive(input logic e, input logic r, input logic [7:0] d);
      enable = e;
      reset  = r;
      inbyte = d;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 8'h5a);
      total++;
      if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready);
      else passed++;
      total++;
      if (outbyte !== 8'h00) $display("FAIL reset_out got %h want 00", outbyte);
      else passed++;
      drive(1'b0, 1'b0, 8'h00);
      total++;
      if ({ready, outbyte} !== 9'h000)
         $display("FAIL reset_idle got %b/%h want 0/00", ready, outbyte);
      else passed++;
   endtask

   task automatic test_block1();
      logic [8:0] exp;
      do_reset();
      for (int n = 0; n < 34; n++) begin
         drive(n < 16, 1'b0, n < 16 ? blk1[n] : 8'h00);
         exp = (n >= 15 && n < 31) ? {1'b1, exp1[n-15]} : 9'h000;
         total++;
         if ({ready, outbyte} !== exp)
            $display("FAIL block1[%0d] got %b/%h want %b/%h",
                     n, ready, outbyte, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp;
      do_reset();
      for (int n = 0; n < 50; n++) begin
         if (n < 16)      drive(1'b1, 1'b0, blk1[n]);
         else if (n < 32) drive(1'b1, 1'b0, blk2[n-16]);
         else             drive(1'b0, 1'b0, 8'h00);
         if (n >= 15 && n < 31)      exp = {1'b1, exp1[n-15]};
         else if (n >= 31 && n < 47) exp = {1'b1, exp2[n-31]};
         else                        exp = 9'h000;
         total++;
         if ({ready, outbyte} !== exp)
            $display("FAIL b2b[%0d] got %b/%h want %b/%h",
                     n, ready, outbyte, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   task automatic test_gap();
      logic [8:0] exp;
      do_reset();
      for (int n = 0; n < 37; n++) begin
         if (n < 8)       drive(1'b1, 1'b0, blk1[n]);
         else if (n < 11) drive(1'b0, 1'b0, 8'hff);
         else if (n < 19) drive(1'b1, 1'b0, blk1[n-3]);
         else             drive(1'b0, 1'b0, 8'hff);
         exp = (n >= 18 && n < 34) ? {1'b1, exp1[n-18]} : 9'h000;
         total++;
         if ({ready, outbyte} !== exp)
            $display("FAIL gap[%0d] got %b/%h want %b/%h",
                     n, ready, outbyte, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_block();
      logic [8:0] exp;
      do_reset();
      for (int n = 0; n < 9; n++) begin
         drive(1'b1, 1'b0, blk2[n]);
         total++;
         if ({ready, outbyte} !== 9'h000)
            $display("FAIL rmb_fill[%0d] got %b/%h want 0/00", n, ready, outbyte);
         else passed++;
      end
      for (int n = 0; n < 2; n++) begin
         drive(1'b1, 1'b1, 8'haa);
         total++;
         if ({ready, outbyte} !== 9'h000)
            $display("FAIL rmb_rst[%0d] got %b/%h want 0/00", n, ready, outbyte);
         else passed++;
      end
      for (int n = 0; n < 34; n++) begin
         drive(n < 16, 1'b0, n < 16 ? blk1[n] : 8'h00);
         exp = (n >= 15 && n < 31) ? {1'b1, exp1[n-15]} : 9'h000;
         total++;
         if ({ready, outbyte} !== exp)
            $display("FAIL rmb[%0d] got %b/%h want %b/%h",
                     n, ready, outbyte, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_stream();
      logic [8:0] exp;
      do_reset();
      for (int n = 0; n < 21; n++) begin
         drive(n < 16, 1'b0, n < 16 ? blk1[n] : 8'h00);
         exp = (n >= 15) ? {1'b1, exp1[n-15]} : 9'h000;
         total++;
         if ({ready, outbyte} !== exp)
            $display("FAIL rms[%0d] got %b/%h want %b/%h",
                     n, ready, outbyte, exp[8], exp[7:0]);
         else passed++;
      end
      drive(1'b0, 1'b1, 8'h00);
      total++;
      if ({ready, outbyte} !== 9'h000)
         $display("FAIL rms_rst got %b/%h want 0/00", ready, outbyte);
      else passed++;
      for (int n = 0; n < 20; n++) begin
         drive(1'b0, 1'b0, 8'h00);
         total++;
         if ({ready, outbyte} !== 9'h000)
            $display("FAIL rms_after[%0d] got %b/%h want 0/00", n, ready, outbyte);
         else passed++;
      end
   endtask

   task automatic test_identity();
      logic [8:0] exp;
      do_reset();
      for (int n = 0; n < 33; n++) begin
         drive(n < 16, 1'b0, n < 16 ? 8'(n) : 8'h00);
         exp = (n >= 15 && n < 31) ? {1'b1, expid[n-15]} : 9'h000;
         total++;
         if ({ready, outbyte} !== exp)
            $display("FAIL ident[%0d] got %b/%h want %b/%h",
                     n, ready, outbyte, exp[8], exp[7:0]);
         else passed++;
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b1;
      enable = 1'b0;
      inbyte = 8'h00;
      test_reset();
      test_block1();
      test_back_to_back();
      test_gap();
      test_reset_mid_block();
      test_reset_mid_stream();
      test_identity();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
